// File: rtl/spi_slave_sync.sv
// SPI mode-0 responder running entirely on mclk: sclk/cs/mosi are oversampled through
// synchronizers, with a one-entry transmit holding buffer and a registered receive word.
module spi_slave_sync #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_FILL   = {DATA_WIDTH{1'b1}}
) (
  input  logic                  mclk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  underrun
);

  localparam int unsigned CntW  = $clog2(DATA_WIDTH + 1);
  localparam int unsigned FillW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {StIdle, StShift, StAbort} state_e;
  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   cs_prev_q, sclk_prev_q;
  logic                   sclk_rise_q, sclk_fall_q, cs_fall_q, cs_rise_q, mosi_q;
  logic [FillW-1:0]       fill_cnt_q;
  logic                   synced;

  logic [DATA_WIDTH-1:0]  tx_shift_q, buf_q, rx_data_q;
  logic [DATA_WIDTH-2:0]  rx_shift_q;
  logic [CntW-1:0]        bit_cnt_q;
  logic                   buf_full_q, rx_valid_q, underrun_q, fill_pend_q;
  logic                   frame_done, frame_load;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  // The synchronized cs is only trusted once the chain has refilled after reset.
  assign synced = (fill_cnt_q == FillW'(SYNC_STAGES));

  always_ff @(posedge mclk) begin
    if (reset) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      mosi_q      <= 1'b0;
      fill_cnt_q  <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      sclk_rise_q <= sclk_s & ~sclk_prev_q;
      sclk_fall_q <= ~sclk_s & sclk_prev_q;
      cs_fall_q   <= ~cs_s & cs_prev_q;
      cs_rise_q   <= cs_s & ~cs_prev_q;
      mosi_q      <= mosi_s;
      if (!synced) fill_cnt_q <= fill_cnt_q + FillW'(1);
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) state_q <= StAbort;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cs_fall_q) state_d = StShift;
      StShift: if (cs_rise_q) state_d = StIdle;
      StAbort: if (synced && cs_s) state_d = StIdle;
      default: state_d = StAbort;
    endcase
  end

  always_comb begin
    busy = (state_q == StShift);
    miso = busy ? tx_shift_q[DATA_WIDTH-1] : 1'b0;
  end

  assign frame_done = (state_q == StShift) && sclk_rise_q &&
                      (bit_cnt_q == CntW'(DATA_WIDTH - 1));
  assign frame_load = ((state_q == StIdle) && cs_fall_q) || frame_done;

  always_ff @(posedge mclk) begin
    if (reset) begin
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      fill_pend_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      if (tx_load && !buf_full_q) begin
        buf_q      <= tx_data;
        buf_full_q <= 1'b1;
      end
      if (frame_load) begin
        if (buf_full_q) begin
          tx_shift_q <= buf_q;
          buf_full_q <= 1'b0;
        end else begin
          tx_shift_q <= IDLE_FILL;
          // A frame-end reload only underruns if another frame really follows.
          if (frame_done) fill_pend_q <= 1'b1;
          else            underrun_q  <= 1'b1;
        end
      end
      if (state_q == StShift) begin
        if (sclk_rise_q) begin
          rx_shift_q <= {rx_shift_q[DATA_WIDTH-3:0], mosi_q};
          if (frame_done) begin
            bit_cnt_q  <= '0;
            rx_data_q  <= {rx_shift_q, mosi_q};
            rx_valid_q <= 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
          if (bit_cnt_q == '0 && fill_pend_q) begin
            underrun_q  <= 1'b1;
            fill_pend_q <= 1'b0;
          end
        end else if (sclk_fall_q && bit_cnt_q != '0) begin
          tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
        end
        if (cs_rise_q) begin
          bit_cnt_q   <= '0;
          fill_pend_q <= 1'b0;
        end
      end
    end
  end

  assign tx_ready = ~buf_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: a behavioural mode-0 master drives frames and
// hand-computed expectations are checked with immediate assertions.
module tb_spi_slave_sync;

  logic       mclk = 1'b0;
  logic       reset, sclk, cs, mosi, miso;
  logic [7:0] tx_data, rx_data;
  logic       tx_load, tx_ready, rx_valid, busy, underrun;

  int total = 0;
  int bad   = 0;
  int rx_cnt = 0;
  int ur_cnt = 0;
  int rx_base, ur_base;
  logic [7:0] got, got2;

  spi_slave_sync dut (
    .mclk     (mclk),
    .reset    (reset),
    .sclk     (sclk),
    .cs       (cs),
    .mosi     (mosi),
    .miso     (miso),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) begin
    if (rx_valid) rx_cnt++;
    if (underrun) ur_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic load(input logic [7:0] d);
    @(negedge mclk);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge mclk);
    tx_load = 1'b0;
  endtask

  // Mode 0 master: mosi set while sclk low, miso sampled on the rising edge.
  task automatic xfer(input int nbits, input logic [7:0] mo, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      wait_n(8);
      sclk = 1'b1;
      mi = {mi[6:0], miso};
      wait_n(8);
      sclk = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_load = 1'b0;
    wait_n(3);
    reset = 1'b0;
    wait_n(6);
    check("rst_miso", miso, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);

    // Single frame
    load(8'hA5);
    check("single_ready_low", tx_ready, 0);
    rx_base = rx_cnt; ur_base = ur_cnt;
    cs = 1'b0;
    wait_n(8);
    check("single_busy", busy, 1);
    check("single_ready_back", tx_ready, 1);
    xfer(8, 8'h46, got);
    wait_n(8);
    check("single_rx_data", rx_data, 8'h46);
    check("single_rx_cnt", rx_cnt - rx_base, 1);
    check("single_miso_word", got, 8'hA5);
    check("single_no_underrun", ur_cnt - ur_base, 0);
    cs = 1'b1;
    wait_n(8);
    check("single_idle_busy", busy, 0);
    check("single_idle_miso", miso, 0);

    // Back-to-back under one cs
    load(8'h12);
    rx_base = rx_cnt; ur_base = ur_cnt;
    cs = 1'b0;
    wait_n(8);
    check("b2b_ready_after_start", tx_ready, 1);
    load(8'h34);
    check("b2b_ready_after_load", tx_ready, 0);
    xfer(8, 8'hC3, got);
    check("b2b_rx_first", rx_data, 8'hC3);
    check("b2b_cnt_first", rx_cnt - rx_base, 1);
    xfer(8, 8'h3C, got2);
    wait_n(8);
    check("b2b_rx_second", rx_data, 8'h3C);
    check("b2b_cnt_second", rx_cnt - rx_base, 2);
    check("b2b_miso_first", got, 8'h12);
    check("b2b_miso_second", got2, 8'h34);
    check("b2b_no_underrun", ur_cnt - ur_base, 0);
    cs = 1'b1;
    wait_n(8);

    // Underrun
    rx_base = rx_cnt; ur_base = ur_cnt;
    cs = 1'b0;
    wait_n(8);
    check("ur_pulse_at_start", ur_cnt - ur_base, 1);
    xfer(8, 8'h55, got);
    wait_n(8);
    check("ur_miso_fill", got, 8'hFF);
    check("ur_rx_data", rx_data, 8'h55);
    check("ur_pulse_once", ur_cnt - ur_base, 1);
    check("ur_rx_cnt", rx_cnt - rx_base, 1);
    cs = 1'b1;
    wait_n(8);

    // Abort after three bits, then a full frame
    rx_base = rx_cnt;
    cs = 1'b0;
    wait_n(8);
    xfer(3, 8'hE0, got);
    cs = 1'b1;
    wait_n(8);
    check("abort_no_valid", rx_cnt - rx_base, 0);
    check("abort_rx_kept", rx_data, 8'h55);
    check("abort_busy", busy, 0);
    cs = 1'b0;
    wait_n(8);
    xfer(8, 8'h46, got);
    wait_n(8);
    check("abort_next_rx", rx_data, 8'h46);
    check("abort_next_cnt", rx_cnt - rx_base, 1);
    cs = 1'b1;
    wait_n(8);

    // Reset mid-frame with cs held low
    load(8'h77);
    cs = 1'b0;
    wait_n(8);
    xfer(4, 8'hF0, got);
    reset = 1'b1;
    wait_n(2);
    check("mid_rst_rx_data", rx_data, 8'h00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_miso", miso, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_underrun", underrun, 0);
    reset = 1'b0;
    rx_base = rx_cnt;
    xfer(4, 8'hFF, got);
    wait_n(8);
    check("mid_rst_ignored_busy", busy, 0);
    check("mid_rst_ignored_miso", miso, 0);
    check("mid_rst_no_valid", rx_cnt - rx_base, 0);
    cs = 1'b1;
    wait_n(8);
    cs = 1'b0;
    wait_n(8);
    xfer(8, 8'h9A, got);
    wait_n(8);
    check("mid_rst_next_rx", rx_data, 8'h9A);
    check("mid_rst_next_cnt", rx_cnt - rx_base, 1);
    cs = 1'b1;
    wait_n(8);

    // Load while buffer full is ignored
    load(8'h11);
    load(8'h22);
    check("ign_ready_low", tx_ready, 0);
    cs = 1'b0;
    wait_n(8);
    xfer(8, 8'h00, got);
    wait_n(8);
    check("ign_miso_word", got, 8'h11);
    check("ign_ready_after", tx_ready, 1);
    check("ign_rx_data", rx_data, 8'h00);
    cs = 1'b1;
    wait_n(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
